vga_sprite_gen: RTL and testbench



---
 rtl/vga_sprite_gen.sv | 252 +++++++++++++++++++++++++
 tb/tb_vga_sprite_gen.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sprite_gen.sv
// vga_sprite_gen
//   Pixel-generation stage behind the VGA sync generator. It draws a
//   background, an optional 1-pixel wall frame and a bouncing square sprite.
//   The sprite moves once per frame, during vertical blanking. It shows
//   HIT_COLOR for HIT_FRAMES frames after it touches a wall.
//
//   Build option: define VGA_SPRITE_BORDER_EN to draw the wall frame in
//   WALL_COLOR. Without it, wall pixels show the background. The bounce
//   limits are the same in both builds.
//
// Ports
//   Clk       system clock (2x pixel rate)
//   reset     synchronous, active-high
//   p_tick    pixel enable, high every other Clk
//   video_on  visible-area flag from the sync generator
//   pixel_x   current column, 0..799
//   pixel_y   current row, 0..524
//   hsync_in  upstream hsync
//   vsync_in  upstream vsync
//   move_en   level: 1 = sprite moves
//   bg_sel    background select (00=00, 01=03, 10=49, 11=92)
//   rgb       pixel colour, RGB 3:3:2, 2 pixel ticks behind the inputs
//   hsync     hsync delayed to line up with rgb
//   vsync     vsync delayed to line up with rgb
module vga_sprite_gen #(
  parameter int unsigned SIZE       = 16,
  parameter int unsigned STEP       = 2,
  parameter int unsigned HIT_FRAMES = 8,
  parameter logic [7:0]  SPR_COLOR  = 8'hE0,
  parameter logic [7:0]  HIT_COLOR  = 8'h1C,
  parameter logic [7:0]  WALL_COLOR = 8'hFF
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       p_tick,
  input  logic       video_on,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       move_en,
  input  logic [1:0] bg_sel,
  output logic [7:0] rgb,
  output logic       hsync,
  output logic       vsync
);

`ifdef VGA_SPRITE_BORDER_EN
  localparam bit BORDER_EN = 1'b1;
`else
  localparam bit BORDER_EN = 1'b0;
`endif

  localparam logic [10:0] X_LIM  = 11'(640 - SIZE);
  localparam logic [10:0] Y_LIM  = 11'(480 - SIZE);
  localparam logic [10:0] STEP11 = 11'(STEP);
  localparam logic [10:0] SIZE11 = 11'(SIZE);
  localparam int unsigned CW     = (HIT_FRAMES > 1) ? $clog2(HIT_FRAMES) : 1;
  localparam logic [CW-1:0] HIT_RELOAD = CW'(HIT_FRAMES - 1);

  typedef enum logic [1:0] {
    S_HOLD,
    S_RUN,
    S_HIT
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] hit_cnt, hit_cnt_nx;
  logic [10:0]   sx, sy;
  logic          dx_neg, dy_neg;

  logic          frame_tick;
  logic          pos_upd;
  logic [10:0]   sx_nx, sy_nx;
  logic          dx_neg_nx, dy_neg_nx;
  logic          bounce_x, bounce_y, bounce;

  // Stage 1 registers
  logic [9:0]    s1_x, s1_y;
  logic          s1_von, s1_hs, s1_vs;

  logic          in_spr, on_wall;
  logic [7:0]    bg_color, pix_color;

  // The first pixel of the first blanking line: the sprite moves here,
  // so a frame is never drawn half at the old and half at the new position.
  assign frame_tick = p_tick && (pixel_x == 10'd0) && (pixel_y == 10'd480);

  // Candidate next position and direction for each axis
  always_comb begin
    sx_nx     = sx;
    dx_neg_nx = dx_neg;
    bounce_x  = 1'b0;
    if (!dx_neg) begin
      if (sx + STEP11 > X_LIM) begin
        sx_nx     = X_LIM;
        dx_neg_nx = 1'b1;
        bounce_x  = 1'b1;
      end else begin
        sx_nx = sx + STEP11;
      end
    end else begin
      if (sx < STEP11) begin
        sx_nx     = '0;
        dx_neg_nx = 1'b0;
        bounce_x  = 1'b1;
      end else begin
        sx_nx = sx - STEP11;
      end
    end
  end

  always_comb begin
    sy_nx     = sy;
    dy_neg_nx = dy_neg;
    bounce_y  = 1'b0;
    if (!dy_neg) begin
      if (sy + STEP11 > Y_LIM) begin
        sy_nx     = Y_LIM;
        dy_neg_nx = 1'b1;
        bounce_y  = 1'b1;
      end else begin
        sy_nx = sy + STEP11;
      end
    end else begin
      if (sy < STEP11) begin
        sy_nx     = '0;
        dy_neg_nx = 1'b0;
        bounce_y  = 1'b1;
      end else begin
        sy_nx = sy - STEP11;
      end
    end
  end

  assign bounce = bounce_x || bounce_y;

  // Next-state logic. A low move_en wins over a frame tick on the same Clk,
  // so the sprite does not move on that tick.
  always_comb begin
    state_nx   = state;
    hit_cnt_nx = hit_cnt;
    pos_upd    = 1'b0;
    case (state)
      S_HOLD: begin
        if (move_en) state_nx = S_RUN;
      end
      S_RUN: begin
        if (!move_en) begin
          state_nx = S_HOLD;
        end else if (frame_tick) begin
          pos_upd = 1'b1;
          if (bounce) begin
            state_nx   = S_HIT;
            hit_cnt_nx = HIT_RELOAD;
          end
        end
      end
      S_HIT: begin
        if (!move_en) begin
          state_nx   = S_HOLD;
          hit_cnt_nx = '0;
        end else if (frame_tick) begin
          pos_upd = 1'b1;
          if (bounce) begin
            hit_cnt_nx = HIT_RELOAD;
          end else if (hit_cnt == '0) begin
            state_nx = S_RUN;
          end else begin
            hit_cnt_nx = hit_cnt - 1'b1;
          end
        end
      end
      default: begin
        state_nx   = S_HOLD;
        hit_cnt_nx = '0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      state   <= S_HOLD;
      hit_cnt <= '0;
      sx      <= 11'd312;
      sy      <= 11'd232;
      dx_neg  <= 1'b0;
      dy_neg  <= 1'b0;
    end else begin
      state   <= state_nx;
      hit_cnt <= hit_cnt_nx;
      if (pos_upd) begin
        sx     <= sx_nx;
        sy     <= sy_nx;
        dx_neg <= dx_neg_nx;
        dy_neg <= dy_neg_nx;
      end
    end
  end

  // Stage 1: capture the incoming pixel
  always_ff @(posedge Clk) begin
    if (reset) begin
      s1_x   <= '0;
      s1_y   <= '0;
      s1_von <= 1'b0;
      s1_hs  <= 1'b0;
      s1_vs  <= 1'b0;
    end else if (p_tick) begin
      s1_x   <= pixel_x;
      s1_y   <= pixel_y;
      s1_von <= video_on;
      s1_hs  <= hsync_in;
      s1_vs  <= vsync_in;
    end
  end

  // Colour selection for the stage-1 pixel
  always_comb begin
    in_spr  = ({1'b0, s1_x} >= sx) && ({1'b0, s1_x} < sx + SIZE11) &&
              ({1'b0, s1_y} >= sy) && ({1'b0, s1_y} < sy + SIZE11);
    on_wall = (s1_x == 10'd0) || (s1_x == 10'd639) ||
              (s1_y == 10'd0) || (s1_y == 10'd479);
    case (bg_sel)
      2'b00:   bg_color = 8'h00;
      2'b01:   bg_color = 8'h03;
      2'b10:   bg_color = 8'h49;
      default: bg_color = 8'h92;
    endcase
    pix_color = bg_color;
    if (!s1_von)
      pix_color = 8'h00;
    else if (in_spr)
      pix_color = (state == S_HIT) ? HIT_COLOR : SPR_COLOR;
    else if (BORDER_EN && on_wall)
      pix_color = WALL_COLOR;
  end

  // Stage 2: register the colour and the syncs together
  always_ff @(posedge Clk) begin
    if (reset) begin
      rgb   <= '0;
      hsync <= 1'b0;
      vsync <= 1'b0;
    end else if (p_tick) begin
      rgb   <= pix_color;
      hsync <= s1_hs;
      vsync <= s1_vs;
    end
  end

endmodule

// File: tb/tb_vga_sprite_gen.sv
module tb_vga_sprite_gen;

  logic       Clk = 1'b0;
  logic       reset;
  logic       p_tick;
  logic       video_on;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       hsync_in;
  logic       vsync_in;
  logic       move_en;
  logic [1:0] bg_sel;
  logic [7:0] rgb;
  logic       hsync;
  logic       vsync;

  int total = 0;
  int bad   = 0;

  // Reference model: sprite position, direction and flash state
  int msx, msy, mdx, mdy;
  bit moving;
  int green_left;

  vga_sprite_gen #(
    .SIZE(16), .STEP(2), .HIT_FRAMES(8),
    .SPR_COLOR(8'hE0), .HIT_COLOR(8'h1C), .WALL_COLOR(8'hFF)
  ) dut (
    .Clk(Clk), .reset(reset), .p_tick(p_tick), .video_on(video_on),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .hsync_in(hsync_in),
    .vsync_in(vsync_in), .move_en(move_en), .bg_sel(bg_sel),
    .rgb(rgb), .hsync(hsync), .vsync(vsync)
  );

  always #5 Clk = ~Clk;

  initial begin
    #10ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_color(int x, int y, bit von, logic [1:0] bg);
    if (!von) return 8'h00;
    if (x >= msx && x < msx + 16 && y >= msy && y < msy + 16)
      return (green_left > 0) ? 8'h1C : 8'hE0;
`ifdef VGA_SPRITE_BORDER_EN
    if (x == 0 || x == 639 || y == 0 || y == 479) return 8'hFF;
`endif
    case (bg)
      2'd0:    return 8'h00;
      2'd1:    return 8'h03;
      2'd2:    return 8'h49;
      default: return 8'h92;
    endcase
  endfunction

  function automatic logic [7:0] exp_bg(logic [1:0] bg);
    case (bg)
      2'd0:    return 8'h00;
      2'd1:    return 8'h03;
      2'd2:    return 8'h49;
      default: return 8'h92;
    endcase
  endfunction

  task automatic model_reset();
    msx = 312; msy = 232; mdx = 1; mdy = 1;
    moving = 0; green_left = 0;
  endtask

  task automatic model_frame();
    bit b;
    b = 0;
    if (!moving) return;
    if (mdx > 0) begin
      if (msx + 2 > 624) begin msx = 624; mdx = -1; b = 1; end
      else msx += 2;
    end else begin
      if (msx < 2) begin msx = 0; mdx = 1; b = 1; end
      else msx -= 2;
    end
    if (mdy > 0) begin
      if (msy + 2 > 464) begin msy = 464; mdy = -1; b = 1; end
      else msy += 2;
    end else begin
      if (msy < 2) begin msy = 0; mdy = 1; b = 1; end
      else msy -= 2;
    end
    if (b) green_left = 8;
    else if (green_left > 0) green_left--;
  endtask

  // One pixel period: new inputs just after a pixel-tick edge, captured on
  // the following pixel-tick edge.
  task automatic pix(input int x, input int y, input bit von, input bit hs, input bit vs);
    pixel_x  = 10'(x);
    pixel_y  = 10'(y);
    video_on = von;
    hsync_in = hs;
    vsync_in = vs;
    p_tick   = 1'b0;
    @(posedge Clk); #1;
    p_tick = 1'b1;
    @(posedge Clk); #1;
    p_tick = 1'b0;
  endtask

  task automatic frame();
    model_frame();
    pix(0, 480, 0, 0, 0);
  endtask

  task automatic check_pix(input int x, input int y, input bit von, input string tag);
    pix(x, y, von, 0, 0);
    pix(700, 500, 0, 0, 0);
    chk(tag, rgb, exp_color(x, y, von, bg_sel));
  endtask

  task automatic set_move(input bit en);
    move_en = en;
    if (en) moving = 1;
    else begin moving = 0; green_left = 0; end
    pix(700, 500, 0, 0, 0);
  endtask

  task automatic rand_check(input string tag);
    int x, y;
    bit von;
    bg_sel = 2'($urandom_range(0, 3));
    von = ($urandom_range(0, 7) != 0);
    case ($urandom_range(0, 3))
      0, 1: begin
        x = msx + int'($urandom_range(0, 19)) - 2;
        y = msy + int'($urandom_range(0, 19)) - 2;
      end
      2: begin
        x = ($urandom_range(0, 1) != 0) ? 0 : 639;
        y = int'($urandom_range(0, 479));
      end
      default: begin
        x = int'($urandom_range(0, 639));
        y = int'($urandom_range(0, 479));
      end
    endcase
    if (x < 0) x = 0;
    if (x > 639) x = 639;
    if (y < 0) y = 0;
    if (y > 479) y = 479;
    check_pix(x, y, von, tag);
  endtask

  initial begin
    reset = 1'b1; move_en = 1'b0; bg_sel = 2'b00;
    pixel_x = 10'd312; pixel_y = 10'd232; video_on = 1'b1;
    hsync_in = 1'b1; vsync_in = 1'b1; p_tick = 1'b0;
    model_reset();

    // Reset dominates even with active pixel ticks and asserted syncs
    repeat (3) begin
      @(posedge Clk); #1; p_tick = 1'b1;
      @(posedge Clk); #1; p_tick = 1'b0;
    end
    chk("reset_rgb", rgb, 8'h00);
    chk("reset_hsync", {7'd0, hsync}, 8'h00);
    chk("reset_vsync", {7'd0, vsync}, 8'h00);
    reset = 1'b0;
    hsync_in = 1'b0; vsync_in = 1'b0;

    // Sprite at its reset position and its edges
    check_pix(312, 232, 1, "rst_spr_tl");
    chk("rst_spr_tl_const", rgb, 8'hE0);
    check_pix(311, 232, 1, "rst_left_of_spr");
    check_pix(327, 247, 1, "rst_spr_br");
    check_pix(328, 247, 1, "rst_right_of_spr");
    check_pix(312, 248, 1, "rst_below_spr");
    check_pix(0, 5, 1, "wall_bg00");
    bg_sel = 2'b01;
    check_pix(0, 5, 1, "wall_bg01");
`ifndef VGA_SPRITE_BORDER_EN
    chk("wall_bg01_const", rgb, 8'h03);
`else
    chk("wall_bg01_const", rgb, 8'hFF);
`endif
    check_pix(312, 232, 0, "blank_over_spr");

    // Latency: hsync pulse at x=656 appears exactly 4 Clk later
    pixel_x = 10'd656; pixel_y = 10'd10; video_on = 1'b0; hsync_in = 1'b1; p_tick = 1'b0;
    @(posedge Clk); #1; chk("lat_clk1", {7'd0, hsync}, 8'h00); p_tick = 1'b1;
    @(posedge Clk); #1; chk("lat_clk2", {7'd0, hsync}, 8'h00);
    hsync_in = 1'b0; pixel_x = 10'd657; p_tick = 1'b0;
    @(posedge Clk); #1; chk("lat_clk3", {7'd0, hsync}, 8'h00); p_tick = 1'b1;
    @(posedge Clk); #1; chk("lat_clk4", {7'd0, hsync}, 8'h01); p_tick = 1'b0;
    @(posedge Clk); #1; chk("lat_hold", {7'd0, hsync}, 8'h01);
    pix(658, 10, 0, 0, 0);
    chk("lat_fall", {7'd0, hsync}, 8'h00);

    // rgb and syncs stay aligned for a visible sprite pixel
    bg_sel = 2'b10;
    pix(327, 247, 1, 1, 1);
    pix(328, 247, 1, 0, 0);
    chk("align_rgb", rgb, 8'hE0);
    chk("align_hsync", {7'd0, hsync}, 8'h01);
    chk("align_vsync", {7'd0, vsync}, 8'h01);
    pix(329, 247, 1, 0, 0);
    chk("align_next_rgb", rgb, 8'h49);
    chk("align_next_hsync", {7'd0, hsync}, 8'h00);

    // Frame ticks in HOLD do not move the sprite
    repeat (3) frame();
    check_pix(312, 232, 1, "hold_ignores_tick");

    // Y bounce after 117 frames
    set_move(1);
    repeat (116) frame();
    check_pix(msx, msy + 15, 1, "pre_ybounce");
    chk("pre_ybounce_const", rgb, 8'hE0);
    frame();
    check_pix(546, 464, 1, "ybounce_tl");
    chk("ybounce_const", rgb, 8'h1C);
    check_pix(545, 464, 1, "ybounce_left");
    check_pix(546, 463, 1, "ybounce_above");
    check_pix(561, 479, 1, "ybounce_br");
    repeat (4) rand_check("rand_hit1");
    repeat (7) frame();
    check_pix(msx, msy, 1, "hit_7_frames");
    frame();
    check_pix(msx, msy, 1, "hit_done");
    chk("hit_done_const", rgb, 8'hE0);

    // X bounce at frame 157
    repeat (157 - 125) frame();
    check_pix(624, 384, 1, "xbounce_tl");
    chk("xbounce_const", rgb, 8'h1C);
    check_pix(639, 399, 1, "xbounce_br");
    check_pix(623, 384, 1, "xbounce_left");
    frame();

    // Dropping move_en on a frame tick mid-HIT: no move, back to normal colour
    move_en = 1'b0; moving = 0; green_left = 0;
    pix(0, 480, 0, 0, 0);
    check_pix(msx, msy, 1, "hold_colour");
    chk("hold_colour_const", rgb, 8'hE0);
    repeat (5) frame();
    check_pix(msx, msy, 1, "hold_pos_tl");
    check_pix(msx - 1, msy, 1, "hold_pos_left");
    check_pix(msx + 15, msy + 15, 1, "hold_pos_br");

    // Random run: move_en toggles, frame ticks, random pixels
    set_move(1);
    for (int i = 0; i < 450; i++) begin
      if ($urandom_range(0, 15) == 0) set_move(!move_en);
      frame();
      if ($urandom_range(0, 1) != 0) rand_check("rand_run");
    end

    // Reset mid-frame with move_en high returns the sprite home
    reset = 1'b1;
    pix(100, 100, 1, 1, 0);
    reset = 1'b0;
    model_reset();
    move_en = 1'b0;
    chk("midreset_rgb", rgb, 8'h00);
    bg_sel = 2'b11;
    check_pix(312, 232, 1, "midreset_home");
    check_pix(311, 231, 1, "midreset_outside");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
